// File: rtl/csp_channel.sv
// ---------------------------------------------------------------------------
// csp_channel
// Point-to-point CSP channel: four-phase bundled-data handshake on the sender
// and receiver sides, decoupled by a single-entry token register.
//
// Ports:
//   clk         in   clock shared by both processes
//   rst_n       in   asynchronous active-low reset
//   snd_req     in   sender request (snd_data valid while high)
//   snd_data    in   sender token [WIDTH-1:0]
//   snd_ack     out  acknowledge to sender
//   rcv_req     out  request to receiver (rcv_data valid while high)
//   rcv_data    out  token presented to receiver [WIDTH-1:0]
//   rcv_ack     in   receiver acknowledge
//   full        out  token register holds an undelivered token
//   xfer_count  out  [15:0] consumed-token counter     (CSP_CHANNEL_XFER_COUNT_EN)
//   stall       out  sender blocked by a full register (CSP_CHANNEL_XFER_COUNT_EN)
//
// Optional feature macro: CSP_CHANNEL_XFER_COUNT_EN
// ---------------------------------------------------------------------------
module csp_channel #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             snd_req,
    input  logic [WIDTH-1:0] snd_data,
    output logic             snd_ack,
    output logic             rcv_req,
    output logic [WIDTH-1:0] rcv_data,
    input  logic             rcv_ack,
    output logic             full
`ifdef CSP_CHANNEL_XFER_COUNT_EN
    ,
    output logic [15:0]      xfer_count,
    output logic             stall
`endif
);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } snd_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_REL
    } rcv_state_t;

    snd_state_t       r_snd_state;
    rcv_state_t       r_rcv_state;
    logic [WIDTH-1:0] r_data;
    logic             r_full;
    logic             r_snd_ack;
    logic             r_rcv_req;
    logic [WIDTH-1:0] r_rcv_data;

    // Capture needs an empty register beforehand, so a same-edge clear never
    // lets a waiting sender bypass into the register.
    logic w_capture;
    logic w_consume;

    assign w_capture = (r_snd_state == S_IDLE) && snd_req && !r_full;
    assign w_consume = (r_rcv_state == R_REQ) && rcv_ack;

    // Sender FSM: capture token, hold ack until request returns to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snd_state <= S_IDLE;
            r_snd_ack   <= 1'b0;
            r_data      <= '0;
        end else begin
            case (r_snd_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_data      <= snd_data;
                        r_snd_ack   <= 1'b1;
                        r_snd_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!snd_req) begin
                        r_snd_ack   <= 1'b0;
                        r_snd_state <= S_IDLE;
                    end
                end
                default: begin
                    r_snd_ack   <= 1'b0;
                    r_snd_state <= S_IDLE;
                end
            endcase
        end
    end

    // Occupancy flag: set by capture, cleared by consumption (never both at once).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (w_consume) begin
            r_full <= 1'b0;
        end else if (w_capture) begin
            r_full <= 1'b1;
        end
    end

    // Receiver FSM: present token, wait for ack, then wait for ack release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcv_state <= R_IDLE;
            r_rcv_req   <= 1'b0;
            r_rcv_data  <= '0;
        end else begin
            case (r_rcv_state)
                R_IDLE: begin
                    // rcv_ack seen here is a protocol violation and is ignored
                    if (r_full) begin
                        r_rcv_data  <= r_data;
                        r_rcv_req   <= 1'b1;
                        r_rcv_state <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (rcv_ack) begin
                        r_rcv_req   <= 1'b0;
                        r_rcv_state <= R_REL;
                    end
                end
                R_REL: begin
                    if (!rcv_ack) begin
                        r_rcv_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rcv_req   <= 1'b0;
                    r_rcv_state <= R_IDLE;
                end
            endcase
        end
    end

    assign snd_ack  = r_snd_ack;
    assign rcv_req  = r_rcv_req;
    assign rcv_data = r_rcv_data;
    assign full     = r_full;

`ifdef CSP_CHANNEL_XFER_COUNT_EN
    logic [15:0] r_xfer_count;

    // Consumption counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= 16'd0;
        end else if (w_consume) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
    // Stall describes the current cycle's request, so it is decoded directly.
    assign stall      = snd_req && r_full && (r_snd_state == S_IDLE);
`endif

endmodule

// File: tb/tb_csp_channel.sv
// ---------------------------------------------------------------------------
// tb_csp_channel
// Self-checking bench for csp_channel: a transaction-level channel model is
// compared against the DUT on every falling edge, directed scenarios pin it
// with literal expectations, and a randomized-delay stream is scoreboarded.
// ---------------------------------------------------------------------------
module tb_csp_channel;

    localparam int unsigned W        = 33;
    localparam int unsigned N_STREAM = 21;
    localparam int unsigned TIMEOUT  = 50;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         snd_req  = 1'b0;
    logic [W-1:0] snd_data = '0;
    logic         rcv_ack  = 1'b0;
    logic         snd_ack;
    logic         rcv_req;
    logic [W-1:0] rcv_data;
    logic         full;
`ifdef CSP_CHANNEL_XFER_COUNT_EN
    logic [15:0]  xfer_count;
    logic         stall;
`endif

    csp_channel #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .snd_req  (snd_req),
        .snd_data (snd_data),
        .snd_ack  (snd_ack),
        .rcv_req  (rcv_req),
        .rcv_data (rcv_data),
        .rcv_ack  (rcv_ack),
        .full     (full)
`ifdef CSP_CHANNEL_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count),
        .stall      (stall)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    // slot: tokens held by the channel (0 or 1); owed: sender still owes a
    // return-to-zero; rx_phase: 0 waiting for token, 1 offering, 2 releasing.
    logic [W-1:0] m_slot_q[$];
    bit           m_owed   = 1'b0;
    int           m_rx_phase = 0;
    logic [W-1:0] m_out    = '0;
    logic [15:0]  m_count  = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        bit had_token;
        if (!rst_n) begin
            m_slot_q.delete();
            m_owed     = 1'b0;
            m_rx_phase = 0;
            m_out      = '0;
            m_count    = 16'd0;
        end else begin
            had_token = (m_slot_q.size() != 0);
            // receiver side acts on the token present before this edge
            if (m_rx_phase == 0) begin
                if (had_token) begin
                    m_out      = m_slot_q[0];
                    m_rx_phase = 1;
                end
            end else if (m_rx_phase == 1) begin
                if (rcv_ack) begin
                    void'(m_slot_q.pop_front());
                    m_count    = m_count + 16'd1;
                    m_rx_phase = 2;
                end
            end else if (!rcv_ack) begin
                m_rx_phase = 0;
            end
            // sender side: accept only into a channel that was empty before the edge
            if (!m_owed) begin
                if (snd_req && !had_token) begin
                    m_slot_q.push_back(snd_data);
                    m_owed = 1'b1;
                end
            end else if (!snd_req) begin
                m_owed = 1'b0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_snd_ack",  64'(snd_ack),  64'(m_owed));
            check("cyc_rcv_req",  64'(rcv_req),  64'(m_rx_phase == 1));
            check("cyc_rcv_data", 64'(rcv_data), 64'(m_out));
            check("cyc_full",     64'(full),     64'(m_slot_q.size() != 0));
`ifdef CSP_CHANNEL_XFER_COUNT_EN
            check("cyc_xfer_count", 64'(xfer_count), 64'(m_count));
            check("cyc_stall", 64'(stall),
                  64'(snd_req && (m_slot_q.size() != 0) && !m_owed));
`endif
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_snd_ack(input logic v);
        int n = 0;
        while (snd_ack !== v && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("wait_snd_ack", 64'(snd_ack), 64'(v));
    endtask

    task automatic wait_rcv_req(input logic v);
        int n = 0;
        while (rcv_req !== v && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("wait_rcv_req", 64'(rcv_req), 64'(v));
    endtask

    // ---------------- stream peers ----------------
    logic [W-1:0] stream_tok[N_STREAM];
    logic [W-1:0] exp_q[$];
    int           delivered = 0;

    task automatic sender_proc();
        for (int i = 0; i < int'(N_STREAM); i++) begin
            repeat ($urandom_range(0, 3)) tick();
            snd_data = stream_tok[i];
            snd_req  = 1'b1;
            exp_q.push_back(stream_tok[i]);
            wait_snd_ack(1'b1);
            repeat ($urandom_range(0, 3)) tick();
            snd_req = 1'b0;
            wait_snd_ack(1'b0);
        end
    endtask

    task automatic receiver_proc();
        logic [W-1:0] e;
        for (int i = 0; i < int'(N_STREAM); i++) begin
            wait_rcv_req(1'b1);
            check("stream_expected_present", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stream_rcv_data", 64'(rcv_data), 64'(e));
            end
            repeat ($urandom_range(0, 3)) tick();
            rcv_ack = 1'b1;
            delivered++;
            wait_rcv_req(1'b0);
            repeat ($urandom_range(0, 3)) tick();
            rcv_ack = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [8:0] bits9;
        bits9 = 9'b101100101;          // 1,0,1,1,0,0,1,0,1 from MSB
        for (int i = 0; i < 9; i++) stream_tok[i] = W'(bits9[8-i]);
        for (int i = 9; i < int'(N_STREAM); i++)
            stream_tok[i] = W'({32'($urandom_range(0, 1)), $urandom()});

        // Reset with peers misbehaving: outputs must stay low.
        #1;
        rst_n    = 1'b0;
        snd_req  = 1'b1;
        rcv_ack  = 1'b1;
        snd_data = W'(64'h0AA);
        #1;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_snd_ack", 64'(snd_ack), 64'd0);
            check("rst_rcv_req", 64'(rcv_req), 64'd0);
            check("rst_full",    64'(full),    64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("post_rst_full_before_edge", 64'(full), 64'd0);
        tick();
        check("post_rst_capture_full", 64'(full),    64'd1);
        check("post_rst_capture_ack",  64'(snd_ack), 64'd1);
        snd_req = 1'b0;
        tick();
        // rcv_ack held high in idle is ignored: token is offered, not consumed
        check("idle_ack_ignored_req",  64'(rcv_req),  64'd1);
        check("idle_ack_ignored_data", 64'(rcv_data), 64'h0AA);
        tick();
        check("idle_ack_consumed_full", 64'(full), 64'd0);
        rcv_ack = 1'b0;
        repeat (2) tick();

        // Single 33-bit transfer.
        snd_data = W'(64'h1_D000_0007);
        snd_req  = 1'b1;
        tick();
        check("single_snd_ack", 64'(snd_ack), 64'd1);
        check("single_full",    64'(full),    64'd1);
        check("single_rcv_req_early", 64'(rcv_req), 64'd0);
        snd_req = 1'b0;
        tick();
        check("single_rcv_req",  64'(rcv_req),  64'd1);
        check("single_rcv_data", 64'(rcv_data), 64'h1_D000_0007);
        rcv_ack = 1'b1;
        tick();
        check("single_rcv_req_drop", 64'(rcv_req), 64'd0);
        check("single_full_clear",   64'(full),    64'd0);
        rcv_ack = 1'b0;
        tick();
        check("single_data_held", 64'(rcv_data), 64'h1_D000_0007);
        tick();

        // Back-pressure: second token waits for the register to empty.
        snd_data = W'(64'h5);
        snd_req  = 1'b1;
        tick();
        snd_req = 1'b0;
        tick();
        check("bp_first_offer", 64'(rcv_data), 64'h5);
        snd_data = W'(64'h9);
        snd_req  = 1'b1;
        repeat (2) tick();
        check("bp_no_ack",   64'(snd_ack),  64'd0);
        check("bp_full",     64'(full),     64'd1);
        check("bp_data_old", 64'(rcv_data), 64'h5);
`ifdef CSP_CHANNEL_XFER_COUNT_EN
        check("bp_stall", 64'(stall), 64'd1);
`endif
        rcv_ack = 1'b1;
        tick();
        check("bp_no_bypass_ack", 64'(snd_ack), 64'd0);
        check("bp_cleared",       64'(full),    64'd0);
        rcv_ack = 1'b0;
        tick();
        check("bp_second_capture", 64'(snd_ack), 64'd1);
        snd_req = 1'b0;
        tick();
        check("bp_second_offer_req",  64'(rcv_req),  64'd1);
        check("bp_second_offer_data", 64'(rcv_data), 64'h9);
        rcv_ack = 1'b1;
        tick();
        rcv_ack = 1'b0;
        repeat (2) tick();

        // Randomized-delay stream, starting with the 9 single-bit tokens.
        fork
            sender_proc();
            receiver_proc();
        join
        repeat (4) tick();
        check("stream_all_delivered", 64'(delivered), 64'(N_STREAM));
        check("stream_no_leftover",   64'(exp_q.size()), 64'd0);
        check("stream_idle_full",     64'(full), 64'd0);
`ifdef CSP_CHANNEL_XFER_COUNT_EN
        check("xfer_count_total", 64'(xfer_count), 64'(4 + N_STREAM));
`endif

        // Asynchronous reset while a token is on offer.
        snd_data = W'(64'h123);
        snd_req  = 1'b1;
        tick();
        snd_req = 1'b0;
        tick();
        check("arst_pre_req", 64'(rcv_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_drop",  64'(rcv_req), 64'd0);
        check("arst_full_drop", 64'(full),    64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_not_delivered", 64'(rcv_req), 64'd0);
        check("arst_full_stays",    64'(full),    64'd0);
`ifdef CSP_CHANNEL_XFER_COUNT_EN
        check("arst_count_zero", 64'(xfer_count), 64'd0);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
